// File: rtl/pulse_sequence_monitor_if.sv
// Pulse code bus from the pulse generator: 8-bit code plus trigger.
interface pulse_sequence_monitor_if;
  logic [7:0] signal_in;
  logic       trigger_in;

  modport master (output signal_in, output trigger_in);
  modport slave  (input  signal_in, input  trigger_in);
endinterface

// File: rtl/pulse_sequence_monitor.sv
// Receive-side checker for the R/M/W pulse bus: phase split, length, order check, lock.
// Optional trigger-position check is built when PULSE_TRIG_CHECK_EN is defined.
module pulse_sequence_monitor #(
  parameter int LEN_W    = 22,
  parameter int SEQ_LOCK = 2
) (
  input  logic                   clk_in,
  input  logic                   rst_n,
  pulse_sequence_monitor_if.slave bus,
  input  logic                   clear_in,
  output logic                   phase_valid,
  output logic [3:0]             phase_slot,
  output logic [7:0]             phase_code,
  output logic [LEN_W-1:0]       phase_len,
  output logic                   locked,
  output logic                   seq_err,
  output logic                   trig_err,
  output logic [15:0]            err_count,
  output logic [31:0]            seq_count
);
  localparam logic [7:0] CODE_SYNC = 8'h89;
  localparam logic [3:0] LOCK_N    = 4'(SEQ_LOCK);

  typedef enum logic {HUNT, TRACK} state_t;

  state_t           state, state_n;
  logic [7:0]       sig_q;
  logic [LEN_W-1:0] run;
  logic [3:0]       exp_slot, exp_slot_n;
  logic [3:0]       good, good_n;
  logic             ph_end, match;
  logic             acc, se, te, seq_inc, lock_set, lock_clr;
  logic [3:0]       acc_slot;
  logic [1:0]       err_inc;
  logic [16:0]      err_sum;

  // Slot table: odd slots are M (81), slots 2 mod 4 are W (85), the rest R/W variants.
  function automatic logic [7:0] exp_code(input logic [3:0] s);
    logic [7:0] c;
    if (s[0])      c = 8'h81;
    else if (s[1]) c = 8'h85;
    else begin
      case (s[3:2])
        2'd0:    c = 8'h89;
        2'd1:    c = 8'h91;
        2'd2:    c = 8'hA1;
        default: c = 8'h83;
      endcase
    end
    return c;
  endfunction

  assign ph_end = (bus.signal_in != sig_q);
  assign match  = (sig_q == exp_code(exp_slot));

  always_comb begin
    state_n    = state;
    exp_slot_n = exp_slot;
    good_n     = good;
    acc        = 1'b0;
    acc_slot   = exp_slot;
    se         = 1'b0;
    seq_inc    = 1'b0;
    lock_set   = 1'b0;
    lock_clr   = 1'b0;
    if (ph_end) begin
      if (state == HUNT) begin
        if (sig_q == CODE_SYNC) begin
          acc        = 1'b1;
          acc_slot   = 4'd0;
          exp_slot_n = 4'd1;
          state_n    = TRACK;
        end
      end else if (match) begin
        acc        = 1'b1;
        exp_slot_n = exp_slot + 4'd1;
        if (exp_slot == 4'd15) begin
          seq_inc  = 1'b1;
          good_n   = (good == 4'd15) ? good : good + 4'd1;
          lock_set = (good_n >= LOCK_N);
        end
      end else begin
        se       = 1'b1;
        lock_clr = 1'b1;
        good_n   = 4'd0;
        // A sync code out of place restarts the sequence instead of dropping lock-in.
        if (sig_q == CODE_SYNC) begin
          acc        = 1'b1;
          acc_slot   = 4'd0;
          exp_slot_n = 4'd1;
        end else begin
          state_n = HUNT;
        end
      end
    end
  end

`ifdef PULSE_TRIG_CHECK_EN
  logic trig_want;
  // Trigger belongs on the first cycle of slot 6, i.e. as an accepted slot 5 hands over to 85.
  assign trig_want = ph_end && match && (exp_slot == 4'd5) && (bus.signal_in == 8'h85);
  assign te        = (state == TRACK) && (bus.trigger_in != trig_want);
`else
  logic unused_trig;
  assign unused_trig = bus.trigger_in;
  assign te          = 1'b0;
`endif

  assign err_inc = {1'b0, se} + {1'b0, te};
  assign err_sum = {1'b0, err_count} + {15'd0, err_inc};

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HUNT;
      exp_slot <= 4'd1;
      good     <= 4'd0;
    end else begin
      state    <= state_n;
      exp_slot <= exp_slot_n;
      good     <= good_n;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sig_q       <= 8'h00;
      run         <= LEN_W'(1);
      phase_valid <= 1'b0;
      phase_slot  <= 4'd0;
      phase_code  <= 8'h00;
      phase_len   <= '0;
      locked      <= 1'b0;
      seq_err     <= 1'b0;
      trig_err    <= 1'b0;
      err_count   <= 16'd0;
      seq_count   <= 32'd0;
    end else begin
      sig_q       <= bus.signal_in;
      run         <= ph_end ? LEN_W'(1) : ((&run) ? run : run + LEN_W'(1));
      phase_valid <= acc;
      seq_err     <= se;
      trig_err    <= te;
      if (acc) begin
        phase_slot <= acc_slot;
        phase_code <= sig_q;
        phase_len  <= run;
      end
      if (lock_clr)      locked <= 1'b0;
      else if (lock_set) locked <= 1'b1;
      if (clear_in) begin
        err_count <= 16'd0;
        seq_count <= 32'd0;
      end else begin
        err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        if (seq_inc) seq_count <= seq_count + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_pulse_sequence_monitor.sv
// Directed bench for pulse_sequence_monitor: phase-level model plus per-cycle compare.
module tb_pulse_sequence_monitor;
  localparam int LEN_W    = 8;
  localparam int SEQ_LOCK = 2;
  localparam int MAXLEN   = (1 << LEN_W) - 1;
  localparam logic [7:0] SEQ [16] = '{8'h89, 8'h81, 8'h85, 8'h81, 8'h91, 8'h81, 8'h85, 8'h81,
                                      8'hA1, 8'h81, 8'h85, 8'h81, 8'h83, 8'h81, 8'h85, 8'h81};
`ifdef PULSE_TRIG_CHECK_EN
  localparam int TRIG_ON = 1;
`else
  localparam int TRIG_ON = 0;
`endif

  logic clk_in = 1'b0;
  logic rst_n, clear_in;
  logic phase_valid, locked, seq_err, trig_err;
  logic [3:0] phase_slot;
  logic [7:0] phase_code;
  logic [LEN_W-1:0] phase_len;
  logic [15:0] err_count;
  logic [31:0] seq_count;

  pulse_sequence_monitor_if bus();

  pulse_sequence_monitor #(.LEN_W(LEN_W), .SEQ_LOCK(SEQ_LOCK)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .bus(bus.slave), .clear_in(clear_in),
    .phase_valid(phase_valid), .phase_slot(phase_slot), .phase_code(phase_code),
    .phase_len(phase_len), .locked(locked), .seq_err(seq_err), .trig_err(trig_err),
    .err_count(err_count), .seq_count(seq_count)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0, failures = 0;
  int pv_cnt = 0, te_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: works on whole phases (code, length) and the slot table.
  logic [7:0] m_cur;
  int m_len, m_next, m_clean;
  bit m_hunt;
  bit e_pv, e_se, e_te, e_lock;
  int e_slot, e_len, e_err;
  logic [7:0] e_code;
  int unsigned e_seq;

  always @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      m_cur <= 8'h00; m_len <= 1; m_next <= 1; m_clean <= 0; m_hunt <= 1'b1;
      e_pv <= 0; e_se <= 0; e_te <= 0; e_lock <= 0;
      e_slot <= 0; e_len <= 0; e_err <= 0; e_code <= 8'h00; e_seq <= 0;
    end else begin : mdl
      bit pv, se, te, want, hunt_n, lock_n;
      int nxt, cln, er;
      int unsigned sq;
      pv = 0; se = 0; te = 0; want = 0;
      hunt_n = m_hunt; lock_n = e_lock; nxt = m_next; cln = m_clean; sq = e_seq;
      if (bus.signal_in != m_cur) begin
        if (m_hunt) begin
          if (m_cur == 8'h89) begin pv = 1; e_slot <= 0; nxt = 1; hunt_n = 0; end
        end else if (m_cur == SEQ[m_next]) begin
          pv = 1; e_slot <= m_next;
          want = (m_next == 5) && (bus.signal_in == 8'h85);
          if (m_next == 15) begin
            sq = sq + 1;
            cln = (cln < 15) ? cln + 1 : 15;
            if (cln >= SEQ_LOCK) lock_n = 1;
          end
          nxt = (m_next + 1) % 16;
        end else begin
          se = 1; lock_n = 0; cln = 0;
          if (m_cur == 8'h89) begin pv = 1; e_slot <= 0; nxt = 1; end
          else hunt_n = 1;
        end
        if (pv) begin e_code <= m_cur; e_len <= (m_len > MAXLEN) ? MAXLEN : m_len; end
        m_len <= 1;
      end else begin
        m_len <= (m_len < 1000000) ? m_len + 1 : m_len;
      end
      if (TRIG_ON != 0 && !m_hunt) te = (bus.trigger_in != want);
      er = e_err + int'(se) + int'(te);
      if (er > 65535) er = 65535;
      if (clear_in) begin er = 0; sq = 0; end
      m_cur <= bus.signal_in; m_hunt <= hunt_n; m_next <= nxt; m_clean <= cln;
      e_pv <= pv; e_se <= se; e_te <= te; e_lock <= lock_n; e_err <= er; e_seq <= sq;
    end
  end

  always @(negedge clk_in) begin
    chk("phase_valid", phase_valid, e_pv);
    chk("phase_slot", phase_slot, e_slot);
    chk("phase_code", phase_code, e_code);
    chk("phase_len", phase_len, e_len);
    chk("locked", locked, e_lock);
    chk("seq_err", seq_err, e_se);
    chk("trig_err", trig_err, e_te);
    chk("err_count", err_count, e_err);
    chk("seq_count", seq_count, e_seq);
    if (phase_valid) pv_cnt++;
    if (trig_err) te_cnt++;
  end

  task automatic cyc(input logic [7:0] c, input logic t, input logic clr);
    @(negedge clk_in);
    bus.signal_in = c; bus.trigger_in = t; clear_in = clr;
  endtask
  task automatic phase(input logic [7:0] c, input int len, input int trig_at);
    for (int i = 0; i < len; i++) cyc(c, i == trig_at, 1'b0);
  endtask
  task automatic slots(input int from, input int to, input int first_len, input int trig_at);
    for (int s = from; s <= to; s++) phase(SEQ[s], (s == from) ? first_len : 3, (s == 6) ? trig_at : -1);
  endtask
  task automatic settle();
    @(posedge clk_in); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; clear_in = 1'b0; bus.signal_in = 8'h00; bus.trigger_in = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk_in);
    #1;
    chk("rst_phase_valid", phase_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_seq_count", seq_count, 0);
    chk("rst_phase_len", phase_len, 0);
    rst_n = 1'b1;
    phase(8'h00, 2, -1);
    settle; pv_cnt = 0;

    // Nominal: 4 sequences of 3-clock phases.
    for (int k = 0; k < 4; k++) begin
      slots(0, 15, (k == 0) ? 3 : 2, 0);
      cyc(8'h89, 0, 0); settle;
      chk("nom_slot15", phase_slot, 15);
      chk("nom_lock", locked, (k >= 1) ? 1 : 0);
    end
    chk("nom_seq_count", seq_count, 4);
    chk("nom_err_count", err_count, 0);
    chk("nom_len", phase_len, 3);
    cyc(8'h89, 0, 0); settle;
    chk("nom_pv_count", pv_cnt, 64);

    // Order error at slot 4, then relock.
    slots(0, 3, 1, 0);
    phase(8'h83, 3, -1);
    cyc(8'h81, 0, 0); settle;
    chk("ord_seq_err", seq_err, 1);
    chk("ord_err_count", err_count, 1);
    chk("ord_locked", locked, 0);
    phase(8'h81, 2, -1);
    slots(6, 15, 3, 0);
    slots(0, 15, 3, 0);
    cyc(8'h89, 0, 0); settle;
    chk("relock_1", locked, 0);
    chk("relock_seq5", seq_count, 5);
    slots(0, 15, 2, 0);
    cyc(8'h89, 0, 0); settle;
    chk("relock_2", locked, 1);
    chk("relock_seq6", seq_count, 6);

    // Resync: 89 in slot 8.
    slots(0, 7, 2, 0);
    phase(8'h89, 3, -1);
    cyc(8'h81, 0, 0); settle;
    chk("rsy_seq_err", seq_err, 1);
    chk("rsy_pv", phase_valid, 1);
    chk("rsy_slot0", phase_slot, 0);
    chk("rsy_err_count", err_count, 2);
    phase(8'h81, 2, -1);
    cyc(8'h85, 0, 0); settle;
    chk("rsy_slot1", phase_slot, 1);
    chk("rsy_pv1", phase_valid, 1);
    phase(8'h85, 2, -1);
    slots(3, 15, 3, 0);
    cyc(8'h89, 0, 0); settle;
    chk("rsy_seq7", seq_count, 7);

    // Clear in the same cycle as a seq_err.
    slots(0, 1, 2, 0);
    phase(8'h83, 3, -1);
    cyc(8'h81, 0, 1); settle;
    chk("clr_seq_err", seq_err, 1);
    chk("clr_err_count", err_count, 0);
    chk("clr_seq_count", seq_count, 0);
    phase(8'h81, 2, -1);
    slots(4, 15, 3, 0);

    // Reset mid slot 10, then lock in on the next 89.
    slots(0, 9, 3, 0);
    phase(8'h85, 2, -1);
    @(negedge clk_in); #1 rst_n = 1'b0;
    #1;
    chk("mrst_locked", locked, 0);
    chk("mrst_slot", phase_slot, 0);
    chk("mrst_code", phase_code, 0);
    repeat (2) @(negedge clk_in);
    #1 rst_n = 1'b1;
    slots(11, 15, 3, 0);
    phase(8'h89, 3, -1);
    cyc(8'h81, 0, 0); settle;
    chk("mrst_pv", phase_valid, 1);
    chk("mrst_slot0", phase_slot, 0);
    phase(8'h81, 2, -1);
    slots(2, 15, 3, 0);
    cyc(8'h89, 0, 0); settle;
    chk("mrst_seq1", seq_count, 1);

    // Length saturation.
    phase(8'h89, 299, -1);
    cyc(8'h81, 0, 0); settle;
    chk("sat_len", phase_len, 8'hFF);
    chk("sat_seq_err", seq_err, 0);
    phase(8'h81, 2, -1);
    slots(2, 15, 3, 0);
    cyc(8'h89, 0, 0); settle;
    chk("sat_locked", locked, 1);
    te_cnt = 0;

    // Trigger one cycle late.
    slots(0, 15, 2, 1);
    cyc(8'h89, 0, 0); settle;
    chk("trg_err_count", err_count, (TRIG_ON != 0) ? 2 : 0);
    chk("trg_locked", locked, 1);
    chk("trg_seq3", seq_count, 3);
    cyc(8'h89, 0, 0); settle;
    chk("trg_strobes", te_cnt, (TRIG_ON != 0) ? 2 : 0);

    repeat (3) @(negedge clk_in);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
